// File: rtl/regfile_dbg_port_pkg.sv
// Shared types for the register-file debug port: command opcodes, FSM states
// and the response beat record.
package regfile_dbg_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;

   typedef enum logic [1:0] {
      CMD_READ    = 2'b00,
      CMD_WRITE   = 2'b01,
      CMD_DUMP    = 2'b10,
      CMD_ILLEGAL = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StHalt,
      StWrite,
      StRead,
      StResp,
      StRelease
   } state_e;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
      logic                 last;
      logic                 err;
   } rsp_t;

endpackage

// File: rtl/regfile_dbg_port_if.sv
// Host-side command and response channels of the register-file debug port.
// The debug transport is the master; the debug port is the slave.
interface regfile_dbg_port_if
   import regfile_dbg_pkg::*;
#(
   parameter int unsigned ADDR_W = RF_ADDR_W,
   parameter int unsigned DATA_W = RF_DATA_W
) ();

   logic              cmd_valid;
   logic              cmd_ready;
   cmd_op_e           cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
   );

endinterface

// File: rtl/regfile_dbg_port.sv
// Debug access initiator: halts the core, reads/writes/dumps the integer
// register file through its debug ports and streams the results back.
module regfile_dbg_port
   import regfile_dbg_pkg::*;
#(
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned ADDR_W       = RF_ADDR_W,
   parameter int unsigned DATA_W       = RF_DATA_W,
   parameter int unsigned HALT_TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_reset,
   regfile_dbg_port_if.slave io_dbg,
   output logic              o_halt_req,
   input  logic              i_halt_ack,
   output logic [ADDR_W-1:0] o_rf_raddr,
   input  logic [DATA_W-1:0] i_rf_rdata,
   output logic [ADDR_W-1:0] o_rf_waddr,
   output logic [DATA_W-1:0] o_rf_wdata,
   output logic              o_rf_wren
);

   localparam int unsigned       CNT_W     = $clog2(HALT_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   state_e            r_state;
   cmd_op_e           r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [CNT_W-1:0]  r_cnt;
   rsp_t              r_rsp;
   logic              r_rsp_valid;
   logic              r_halt_req;
   logic [ADDR_W-1:0] r_rf_raddr;
   logic [ADDR_W-1:0] r_rf_waddr;
   logic [DATA_W-1:0] r_rf_wdata;
   logic              r_rf_wren;

   logic [CNT_W-1:0]  w_cnt_inc;
   logic [ADDR_W-1:0] w_addr_inc;

   assign w_cnt_inc  = r_cnt + 1'b1;
   assign w_addr_inc = r_addr + 1'b1;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= StIdle;
         r_op        <= CMD_READ;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_rsp       <= '0;
         r_rsp_valid <= 1'b0;
         r_halt_req  <= 1'b0;
         r_rf_raddr  <= '0;
         r_rf_waddr  <= '0;
         r_rf_wdata  <= '0;
         r_rf_wren   <= 1'b0;
      end else begin
         // Register-file drive is only live for the single WRITE/READ cycle.
         r_rf_raddr <= '0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_rf_wren  <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (io_dbg.cmd_valid) begin
                  r_op    <= io_dbg.cmd_op;
                  r_addr  <= io_dbg.cmd_addr;
                  r_wdata <= io_dbg.cmd_wdata;
                  if (io_dbg.cmd_op == CMD_ILLEGAL) begin
                     r_rsp       <= '{addr: io_dbg.cmd_addr, data: '0, last: 1'b1, err: 1'b1};
                     r_rsp_valid <= 1'b1;
                     r_state     <= StResp;
                  end else begin
                     r_cnt      <= '0;
                     r_halt_req <= 1'b1;
                     r_state    <= StHalt;
                  end
               end
            end
            StHalt: begin
               if (i_halt_ack) begin
                  if (r_op == CMD_WRITE) begin
                     r_rf_waddr <= r_addr;
                     r_rf_wdata <= r_wdata;
                     r_rf_wren  <= (r_addr != '0);
                     r_state    <= StWrite;
                  end else begin
                     if (r_op == CMD_DUMP) begin
                        r_addr     <= '0;
                        r_rf_raddr <= '0;
                     end else begin
                        r_rf_raddr <= r_addr;
                     end
                     r_state <= StRead;
                  end
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == CNT_W'(HALT_TIMEOUT)) begin
                     r_rsp       <= '{addr: r_addr, data: '0, last: 1'b1, err: 1'b1};
                     r_rsp_valid <= 1'b1;
                     r_state     <= StResp;
                  end
               end
            end
            StWrite: begin
               // Read back the same register so the response shows what landed.
               r_rf_raddr <= r_addr;
               r_state    <= StRead;
            end
            StRead: begin
               r_rsp.addr  <= r_addr;
               r_rsp.data  <= i_rf_rdata;
               r_rsp.last  <= (r_op != CMD_DUMP) || (r_addr == LAST_ADDR);
               r_rsp.err   <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= StResp;
            end
            StResp: begin
               if (io_dbg.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  if (r_op == CMD_DUMP && !r_rsp.err && r_addr != LAST_ADDR) begin
                     r_addr     <= w_addr_inc;
                     r_rf_raddr <= w_addr_inc;
                     r_state    <= StRead;
                  end else if (r_halt_req) begin
                     r_halt_req <= 1'b0;
                     r_state    <= StRelease;
                  end else begin
                     r_state <= StIdle;
                  end
               end
            end
            StRelease: begin
               // Wait for the core to drop ack so the next command cannot see it.
               if (!i_halt_ack) begin
                  r_state <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign io_dbg.cmd_ready = (r_state == StIdle);
   assign io_dbg.rsp_valid = r_rsp_valid;
   assign io_dbg.rsp_addr  = r_rsp.addr;
   assign io_dbg.rsp_data  = r_rsp.data;
   assign io_dbg.rsp_last  = r_rsp.last;
   assign io_dbg.rsp_err   = r_rsp.err;

   assign o_halt_req = r_halt_req;
   assign o_rf_raddr = r_rf_raddr;
   assign o_rf_waddr = r_rf_waddr;
   assign o_rf_wdata = r_rf_wdata;
   assign o_rf_wren  = r_rf_wren;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Self-checking bench for regfile_dbg_port: directed vector table, random
// commands against a register-array model, dump, timeout and reset cases.
module tb_regfile_dbg_port;
   import regfile_dbg_pkg::*;

   localparam int unsigned NR = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned HT = 255;

   logic          i_clk = 1'b0;
   logic          i_reset = 1'b0;
   logic          o_halt_req;
   logic          i_halt_ack;
   logic [AW-1:0] o_rf_raddr;
   logic [DW-1:0] i_rf_rdata;
   logic [AW-1:0] o_rf_waddr;
   logic [DW-1:0] o_rf_wdata;
   logic          o_rf_wren;

   regfile_dbg_port_if #(.ADDR_W(AW), .DATA_W(DW)) dbg ();

   regfile_dbg_port #(
      .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .HALT_TIMEOUT(HT)
   ) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .io_dbg     (dbg),
      .o_halt_req (o_halt_req),
      .i_halt_ack (i_halt_ack),
      .o_rf_raddr (o_rf_raddr),
      .i_rf_rdata (i_rf_rdata),
      .o_rf_waddr (o_rf_waddr),
      .o_rf_wdata (o_rf_wdata),
      .o_rf_wren  (o_rf_wren)
   );

   always #5 i_clk = ~i_clk;

   // Register file environment: x0 hardwired, combinational read.
   logic [DW-1:0] rf [NR];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_a = '0;
   logic [DW-1:0] pl_d = '0;
   always @(posedge i_clk) begin
      if (pl_en) rf[pl_a] <= pl_d;
      else if (o_rf_wren) rf[o_rf_waddr] <= o_rf_wdata;
   end
   assign i_rf_rdata = (o_rf_raddr == '0) ? '0 : rf[o_rf_raddr];

   // Core halt model: either bench-driven ack or ack following halt_req.
   logic ack_mode = 1'b0;
   logic ack_man = 1'b0;
   logic ack_q = 1'b0;
   always @(posedge i_clk) ack_q <= o_halt_req;
   assign i_halt_ack = ack_mode ? ack_q : ack_man;

   int wren_cnt = 0;
   int halt_cnt = 0;
   always @(posedge i_clk) begin
      if (o_rf_wren) wren_cnt <= wren_cnt + 1;
      if (o_halt_req) halt_cnt <= halt_cnt + 1;
   end

   logic [DW-1:0] exp_rf [NR];
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]    op;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_data;
      logic          exp_err;
      int            exp_lat;
      int            exp_wren;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge i_clk);
      pl_en = 1'b1; pl_a = a; pl_d = d;
      @(posedge i_clk); #1;
      pl_en = 1'b0;
      exp_rf[a] = (a == '0) ? '0 : d;
   endtask

   task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int g = 0;
      @(negedge i_clk);
      while (!dbg.cmd_ready && g < 1000) begin
         @(negedge i_clk);
         g++;
      end
      if (g >= 1000) chk("cmd_ready_wait", 64'(dbg.cmd_ready), 64'd1);
      dbg.cmd_valid = 1'b1;
      dbg.cmd_op    = cmd_op_e'(op);
      dbg.cmd_addr  = a;
      dbg.cmd_wdata = d;
      @(posedge i_clk); #1;
      dbg.cmd_valid = 1'b0;
   endtask

   // Latency counts clock edges from the acceptance edge (first negedge = 1).
   task automatic get_beat(input bit bp, output int lat, output logic [AW-1:0] a,
                           output logic [DW-1:0] d, output logic l, output logic e);
      bit             seen = 1'b0;
      logic [AW+DW+1:0] held = '0;
      lat = 0; a = '0; d = '0; l = 1'b0; e = 1'b0;
      while (lat < 2000) begin
         @(negedge i_clk);
         lat++;
         if (dbg.rsp_valid) begin
            if (seen) chk("rsp_stable", 64'({dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last,
                                              dbg.rsp_err}), 64'(held));
            seen = 1'b1;
            held = {dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last, dbg.rsp_err};
            if (!bp || $urandom_range(0, 2) != 0) begin
               a = dbg.rsp_addr; d = dbg.rsp_data; l = dbg.rsp_last; e = dbg.rsp_err;
               dbg.rsp_ready = 1'b1;
               @(posedge i_clk); #1;
               dbg.rsp_ready = 1'b0;
               return;
            end
         end
      end
      chk("rsp_wait", 64'd0, 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, 64'(dbg.rsp_valid), 64'd0);
      chk({tag, "_rsp_last"}, 64'(dbg.rsp_last), 64'd0);
      chk({tag, "_rsp_err"}, 64'(dbg.rsp_err), 64'd0);
      chk({tag, "_rsp_addr"}, 64'(dbg.rsp_addr), 64'd0);
      chk({tag, "_rsp_data"}, 64'(dbg.rsp_data), 64'd0);
      chk({tag, "_halt_req"}, 64'(o_halt_req), 64'd0);
      chk({tag, "_rf_wren"}, 64'(o_rf_wren), 64'd0);
      chk({tag, "_rf_raddr"}, 64'(o_rf_raddr), 64'd0);
      chk({tag, "_rf_waddr"}, 64'(o_rf_waddr), 64'd0);
      chk({tag, "_rf_wdata"}, 64'(o_rf_wdata), 64'd0);
      chk({tag, "_cmd_ready"}, 64'(dbg.cmd_ready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      vec_t          vt [6];
      int            lat;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic          rl;
      logic          re;

      dbg.cmd_valid = 1'b0; dbg.cmd_op = CMD_READ; dbg.cmd_addr = '0; dbg.cmd_wdata = '0;
      dbg.rsp_ready = 1'b0;
      for (int i = 0; i < int'(NR); i++) exp_rf[i] = '0;

      repeat (3) @(posedge i_clk);
      #1;
      check_reset_outputs("reset");
      @(negedge i_clk);
      i_reset = 1'b1;

      for (int i = 1; i < int'(NR); i++) preload(AW'(i), '0);
      preload(5'd5, 32'hDEADBEEF);

      // Directed vectors, ack already high so latencies are exact.
      vt[0] = '{op: 2'b00, addr: 5'd5,  wdata: 32'h0,        exp_data: 32'hDEADBEEF,
                exp_err: 1'b0, exp_lat: 3, exp_wren: 0};
      vt[1] = '{op: 2'b01, addr: 5'd7,  wdata: 32'h12345678, exp_data: 32'h12345678,
                exp_err: 1'b0, exp_lat: 4, exp_wren: 1};
      vt[2] = '{op: 2'b01, addr: 5'd0,  wdata: 32'hFFFFFFFF, exp_data: 32'h0,
                exp_err: 1'b0, exp_lat: 4, exp_wren: 0};
      vt[3] = '{op: 2'b11, addr: 5'd9,  wdata: 32'h55,       exp_data: 32'h0,
                exp_err: 1'b1, exp_lat: 1, exp_wren: 0};
      vt[4] = '{op: 2'b00, addr: 5'd7,  wdata: 32'h0,        exp_data: 32'h12345678,
                exp_err: 1'b0, exp_lat: 3, exp_wren: 0};
      vt[5] = '{op: 2'b01, addr: 5'd31, wdata: 32'hA5A5A5A5, exp_data: 32'hA5A5A5A5,
                exp_err: 1'b0, exp_lat: 4, exp_wren: 1};

      for (int i = 0; i < 6; i++) begin
         int w0;
         int h0;
         ack_man = (vt[i].op != 2'b11);
         w0 = wren_cnt;
         h0 = halt_cnt;
         issue(vt[i].op, vt[i].addr, vt[i].wdata);
         get_beat(1'b0, lat, ra, rd, rl, re);
         chk("vec_lat", 64'(lat), 64'(vt[i].exp_lat));
         chk("vec_addr", 64'(ra), 64'(vt[i].addr));
         chk("vec_data", 64'(rd), 64'(vt[i].exp_data));
         chk("vec_last", 64'(rl), 64'd1);
         chk("vec_err", 64'(re), 64'(vt[i].exp_err));
         if (vt[i].op == 2'b01 && vt[i].addr != '0) exp_rf[vt[i].addr] = vt[i].wdata;
         @(negedge i_clk);
         if (vt[i].op != 2'b11) begin
            chk("vec_release_halt_req", 64'(o_halt_req), 64'd0);
            chk("vec_release_busy", 64'(dbg.cmd_ready), 64'd0);
            ack_man = 1'b0;
            @(negedge i_clk);
         end else begin
            chk("vec_illegal_no_halt", 64'(halt_cnt - h0), 64'd0);
         end
         chk("vec_ready_after", 64'(dbg.cmd_ready), 64'd1);
         chk("vec_wren_pulses", 64'(wren_cnt - w0), 64'(vt[i].exp_wren));
      end

      // Random commands against the array model, ack following halt_req.
      ack_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int            sel;
         logic [1:0]    op;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         sel = int'($urandom_range(0, 9));
         op = (sel < 4 || sel == 9) ? 2'b00 : (sel < 8) ? 2'b01 : 2'b11;
         a = AW'($urandom_range(0, NR - 1));
         d = $urandom;
         issue(op, a, d);
         if (op == 2'b01 && a != '0) exp_rf[a] = d;
         get_beat(1'b1, lat, ra, rd, rl, re);
         chk("rnd_addr", 64'(ra), 64'(a));
         chk("rnd_data", 64'(rd), (op == 2'b11) ? 64'd0 : 64'(exp_rf[a]));
         chk("rnd_last", 64'(rl), 64'd1);
         chk("rnd_err", 64'(re), 64'(op == 2'b11));
      end

      // Ack arriving in the last allowed halt cycle still succeeds.
      @(negedge i_clk);
      @(negedge i_clk);
      ack_mode = 1'b0;
      ack_man  = 1'b0;
      issue(2'b00, 5'd31, '0);
      for (int k = 1; k < int'(HT); k++) @(negedge i_clk);
      @(negedge i_clk);
      ack_man = 1'b1;
      get_beat(1'b0, lat, ra, rd, rl, re);
      chk("ack_edge_err", 64'(re), 64'd0);
      chk("ack_edge_data", 64'(rd), 64'(exp_rf[31]));
      ack_man = 1'b0;

      // No ack at all: error response after the timeout.
      issue(2'b00, 5'd3, '0);
      get_beat(1'b0, lat, ra, rd, rl, re);
      chk("tmo_lat", 64'(lat), 64'(HT + 1));
      chk("tmo_err", 64'(re), 64'd1);
      chk("tmo_last", 64'(rl), 64'd1);
      chk("tmo_data", 64'(rd), 64'd0);
      @(negedge i_clk);
      chk("tmo_halt_req", 64'(o_halt_req), 64'd0);
      @(negedge i_clk);
      chk("tmo_release_1cyc", 64'(dbg.cmd_ready), 64'd1);

      // Full dump under random back-pressure.
      for (int i = 1; i < int'(NR); i++) preload(AW'(i), DW'(i * 32'h11));
      ack_mode = 1'b1;
      begin
         int nb;
         bit done;
         nb = 0;
         done = 1'b0;
         issue(2'b10, 5'd17, '0);
         while (!done && nb < 40) begin
            get_beat(1'b1, lat, ra, rd, rl, re);
            chk("dump_addr", 64'(ra), 64'(nb % 32));
            chk("dump_data", 64'(rd), 64'(exp_rf[nb % 32]));
            chk("dump_last", 64'(rl), 64'(nb == int'(NR) - 1));
            chk("dump_err", 64'(re), 64'd0);
            nb++;
            done = rl;
         end
         chk("dump_beats", 64'(nb), 64'(NR));
      end

      // Reset while a dump is in flight, then a normal read.
      issue(2'b10, 5'd0, '0);
      for (int b = 0; b < 10; b++) get_beat(1'b0, lat, ra, rd, rl, re);
      @(negedge i_clk);
      i_reset = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge i_clk);
      i_reset = 1'b1;
      issue(2'b00, 5'd5, '0);
      get_beat(1'b0, lat, ra, rd, rl, re);
      chk("post_reset_addr", 64'(ra), 64'd5);
      chk("post_reset_data", 64'(rd), 64'(exp_rf[5]));
      chk("post_reset_err", 64'(re), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
